// File: rtl/data_sram_responder.sv
// Word-addressed SRAM behind a CPU data port: requests are accepted combinationally,
// executed at the accepting edge, and answered in order after a fixed LAT-cycle delay.
module data_sram_responder #(
   parameter int ADDR_W = 12,
   parameter int LAT    = 2,
   parameter int OUTST  = 2
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic [31:0] addr,
   input  logic [3:0]  wstrb,
   input  logic [31:0] wdata,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [31:0] rdata
);

   localparam int            PW       = (OUTST > 1) ? $clog2(OUTST) : 1;
   localparam int            CW       = 3;
   localparam logic [CW-1:0] FULL     = CW'(OUTST);
   localparam logic [PW-1:0] LAST     = PW'(OUTST - 1);
   localparam logic [1:0]    TMR_INIT = 2'(LAT - 1);

   logic [31:0]       mem [0:(1 << ADDR_W) - 1];

   logic [OUTST-1:0]  ent_vld;
   logic [OUTST-1:0]  ent_wr;
   logic [1:0]        ent_tmr  [OUTST];
   logic [31:0]       ent_data [OUTST];

   logic [PW-1:0]     rd_ptr;
   logic [PW-1:0]     wr_ptr;
   logic [CW-1:0]     count;

   logic [ADDR_W-1:0] idx;
   logic              accept;
   logic              retire;
   logic              unused_bits;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST) ? '0 : p + 1'b1;
   endfunction

   assign idx         = addr[ADDR_W+1:2];
   assign unused_bits = ^{size, addr[31:ADDR_W+2], addr[1:0]};

   assign retire  = ent_vld[rd_ptr] && (ent_tmr[rd_ptr] == 2'd0);
   // A slot freed by this cycle's retire may be refilled in the same cycle.
   assign addr_ok = (count < FULL) || retire;
   assign accept  = rstn && req && addr_ok;
   assign data_ok = retire;
   assign rdata   = (retire && !ent_wr[rd_ptr]) ? ent_data[rd_ptr] : 32'd0;

   // Response queue control: pop before push so a full queue can retire and refill one slot.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         ent_vld <= '0;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count   <= '0;
      end else begin
         for (int i = 0; i < OUTST; i++) begin
            if (ent_vld[i] && (ent_tmr[i] != 2'd0)) begin
               ent_tmr[i] <= ent_tmr[i] - 2'd1;
            end
         end
         if (retire) begin
            ent_vld[rd_ptr] <= 1'b0;
            rd_ptr          <= ptr_inc(rd_ptr);
         end
         if (accept) begin
            ent_vld[wr_ptr] <= 1'b1;
            ent_tmr[wr_ptr] <= TMR_INIT;
            wr_ptr          <= ptr_inc(wr_ptr);
         end
         case ({accept, retire})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Load data is sampled before this edge's store lands, which is fine: one request per cycle.
   always_ff @(posedge clk) begin
      if (accept) begin
         ent_data[wr_ptr] <= mem[idx];
         ent_wr[wr_ptr]   <= wr;
      end
   end

   always_ff @(posedge clk) begin
      if (accept && wr) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) begin
               mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
   end

endmodule
